// File: rtl/axi_axis_writer_pkg.sv
// Shared constants for the AXI-Lite write to AXI-Stream bridge.
package axi_axis_writer_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_axis_writer.sv
// AXI4-Lite write slave: each single-beat register write becomes one AXI4-Stream word,
// with TLAST taken from one address bit. Writes are posted when the word is registered.
module axi_axis_writer
    import axi_axis_writer_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int LAST_ADDR_BIT  = 2
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready
);

    localparam int NUM_BYTES = AXI_DATA_WIDTH / 8;

    logic                      aw_full_reg;
    logic                      aw_last_reg;
    logic                      w_full_reg;
    logic [AXI_DATA_WIDTH-1:0] w_data_reg;
    logic [AXI_DATA_WIDTH-1:0] masked_wdata;
    logic                      aw_hs;
    logic                      w_hs;
    logic                      commit;
    logic                      unused_addr_bits;

    // Only one address bit matters; fold the rest so they are visibly consumed.
    assign unused_addr_bits = ^s_axi_awaddr;

    // Ready depends only on holding-register state, never on tready/bready.
    assign s_axi_awready = ~aw_full_reg;
    assign s_axi_wready  = ~w_full_reg;
    assign s_axi_bresp   = RESP_OKAY;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_strb
            assign masked_wdata[gi*8 +: 8] = s_axi_wstrb[gi] ? s_axi_wdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    // A pair moves forward only when both the stream slot and the response slot free up.
    assign commit = aw_full_reg & w_full_reg
                  & (~m_axis_tvalid | m_axis_tready)
                  & (~s_axi_bvalid  | s_axi_bready);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full_reg   <= 1'b0;
            aw_last_reg   <= 1'b0;
            w_full_reg    <= 1'b0;
            w_data_reg    <= '0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            s_axi_bvalid  <= 1'b0;
        end else begin
            // aw_hs/w_hs require an empty slot and commit requires a full one, so they never collide.
            if (aw_hs) begin
                aw_full_reg <= 1'b1;
                aw_last_reg <= s_axi_awaddr[LAST_ADDR_BIT];
            end else if (commit) begin
                aw_full_reg <= 1'b0;
            end

            if (w_hs) begin
                w_full_reg <= 1'b1;
                w_data_reg <= masked_wdata;
            end else if (commit) begin
                w_full_reg <= 1'b0;
            end

            if (commit) begin
                m_axis_tdata  <= w_data_reg;
                m_axis_tlast  <= aw_last_reg;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (commit) begin
                s_axi_bvalid <= 1'b1;
            end else if (s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_axis_writer.sv
// Scoreboard bench for axi_axis_writer: directed writes push expected words, a negedge
// monitor checks stream and response handshakes independently of the stimulus.
module tb_axi_axis_writer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b1;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    int          b_exp = 0;
    int          b_seen = 0;
    int          words_seen = 0;
    logic        writer_done = 1'b0;

    always #5 aclk = ~aclk;

    axi_axis_writer #(
        .AXI_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(16),
        .LAST_ADDR_BIT(2)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end else begin
            $display("ok   %s = 0x%0h", name, actual);
        end
    endtask

    task automatic send_aw(input logic [15:0] addr);
        int n = 0;
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (s_axi_awready) break;
            n++;
            if (n > 500) begin
                checks++; errors++;
                $display("FAIL aw_timeout: awready stayed 0, expected 1 within 500 cycles");
                break;
            end
        end
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        s_axi_wvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (s_axi_wready) break;
            n++;
            if (n > 500) begin
                checks++; errors++;
                $display("FAIL w_timeout: wready stayed 0, expected 1 within 500 cycles");
                break;
            end
        end
        @(posedge aclk); #1;
        s_axi_wvalid = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] data, input logic last);
        exp_q.push_back({last, data});
        b_exp++;
    endtask

    task automatic write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input logic [31:0] exp_data, input logic exp_last);
        expect_word(exp_data, exp_last);
        fork
            send_aw(addr);
            send_w(data, strb);
        join
    endtask

    task automatic cycle();
        @(posedge aclk); #1;
    endtask

    // Monitor: sampled on negedge, so a valid&ready seen here completes at the next posedge.
    logic        stall_prev = 1'b0;
    logic [32:0] stall_word = '0;
    always @(negedge aclk) begin
        if (!aresetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
                check("hold_word", {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, stall_word});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word: got 0x%0h last=%0b, expected no word",
                             m_axis_tdata, m_axis_tlast);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("stream_word", {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, e});
                end
            end
            if (s_axi_bvalid && s_axi_bready) begin
                b_seen++;
                check("bresp", {62'd0, s_axi_bresp}, 64'd0);
            end
            stall_prev = m_axis_tvalid & ~m_axis_tready;
            stall_word = {m_axis_tlast, m_axis_tdata};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_awready", {63'd0, s_axi_awready}, 64'd1);
        check("rst_wready",  {63'd0, s_axi_wready},  64'd1);
        check("rst_bvalid",  {63'd0, s_axi_bvalid},  64'd0);
        check("rst_tvalid",  {63'd0, m_axis_tvalid}, 64'd0);
        check("rst_tdata",   {32'd0, m_axis_tdata},  64'd0);
        check("rst_tlast",   {63'd0, m_axis_tlast},  64'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        cycle();

        // Same-cycle AW+W; word and response one cycle after the pair lands
        write(16'h0000, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0);
        check("lat_tvalid_n", {63'd0, m_axis_tvalid}, 64'd0);
        cycle();
        check("lat_tvalid_n1", {63'd0, m_axis_tvalid}, 64'd1);
        check("lat_bvalid_n1", {63'd0, s_axi_bvalid},  64'd1);
        cycle();
        check("one_cycle_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("one_cycle_bvalid", {63'd0, s_axi_bvalid},  64'd0);

        // W three cycles ahead of AW
        expect_word(32'h12345678, 1'b1);
        send_w(32'h12345678, 4'hF);
        for (int i = 0; i < 3; i++) begin
            check("w_first_wready", {63'd0, s_axi_wready},  64'd0);
            check("w_first_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
            cycle();
        end
        send_aw(16'h0004);
        repeat (3) cycle();

        // Byte strobes
        write(16'h0000, 32'hAABBCCDD, 4'h5, 32'h00BB00DD, 1'b0);
        repeat (3) cycle();

        // Stream backpressure with three writes in flight
        m_axis_tready = 1'b0;
        writer_done = 1'b0;
        fork
            begin
                write(16'h0000, 32'h11111111, 4'hF, 32'h11111111, 1'b0);
                write(16'h0004, 32'h22222222, 4'hF, 32'h22222222, 1'b1);
                write(16'h0000, 32'h33333333, 4'hF, 32'h33333333, 1'b0);
                writer_done = 1'b1;
            end
        join_none
        repeat (10) cycle();
        check("bp_awready", {63'd0, s_axi_awready}, 64'd0);
        check("bp_wready",  {63'd0, s_axi_wready},  64'd0);
        check("bp_tdata",   {32'd0, m_axis_tdata},  64'h11111111);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 200 && !writer_done; i++) cycle();
        check("bp_writer_done", {63'd0, writer_done}, 64'd1);
        repeat (4) cycle();

        // Response backpressure blocks the next commit
        s_axi_bready = 1'b0;
        write(16'h0000, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5, 1'b0);
        repeat (2) cycle();
        write(16'h0004, 32'h5A5A5A5A, 4'hF, 32'h5A5A5A5A, 1'b1);
        repeat (4) cycle();
        check("bstall_tvalid",  {63'd0, m_axis_tvalid}, 64'd0);
        check("bstall_awready", {63'd0, s_axi_awready}, 64'd0);
        check("bstall_bvalid",  {63'd0, s_axi_bvalid},  64'd1);
        s_axi_bready = 1'b1;
        cycle();
        s_axi_bready = 1'b0;
        check("bpulse_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
        check("bpulse_bvalid", {63'd0, s_axi_bvalid},  64'd1);
        cycle();
        s_axi_bready = 1'b1;
        repeat (3) cycle();

        // Asynchronous reset with a word and a response pending
        m_axis_tready = 1'b0;
        s_axi_bready  = 1'b0;
        write(16'h0000, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1'b0);
        cycle();
        check("pre_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
        check("pre_rst_bvalid", {63'd0, s_axi_bvalid},  64'd1);
        #2;
        aresetn = 1'b0;
        void'(exp_q.pop_back());
        b_exp--;
        #1;
        check("async_tvalid",  {63'd0, m_axis_tvalid}, 64'd0);
        check("async_bvalid",  {63'd0, s_axi_bvalid},  64'd0);
        check("async_awready", {63'd0, s_axi_awready}, 64'd1);
        check("async_wready",  {63'd0, s_axi_wready},  64'd1);
        cycle();
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        s_axi_bready  = 1'b1;
        repeat (5) cycle();
        check("post_rst_tvalid",  {63'd0, m_axis_tvalid}, 64'd0);
        check("post_rst_bvalid",  {63'd0, s_axi_bvalid},  64'd0);
        check("post_rst_awready", {63'd0, s_axi_awready}, 64'd1);
        check("post_rst_wready",  {63'd0, s_axi_wready},  64'd1);

        write(16'h0004, 32'h0BADCAFE, 4'hC, 32'h0BAD0000, 1'b1);
        repeat (5) cycle();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("word_count",  64'(words_seen), 64'd9);
        check("resp_count",  64'(b_seen), 64'(b_exp));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
